// File: rtl/branch_resolve_predict_if.sv
// branch_resolve_predict_if: fetch predict port (pred_*) and execute resolve port (res_*, funct3, flags, result pulses, stats)
interface branch_resolve_predict_if #(
  parameter int XLEN = 32,
  parameter int CNT_W = 16
);
  logic pred_valid;
  logic [XLEN-1:0] pred_pc;
  logic pred_taken;
  logic pred_ack;
  logic res_valid;
  logic res_branch;
  logic [XLEN-1:0] res_pc;
  logic [2:0] funct3;
  logic zf;
  logic cf;
  logic sf;
  logic vf;
  logic res_pred_taken;
  logic actual_taken;
  logic mispredict;
  logic illegal_br;
  logic [CNT_W-1:0] br_count;
  logic [CNT_W-1:0] mispred_count;
  modport master (
    output pred_valid, pred_pc, res_valid, res_branch, res_pc, funct3, zf, cf, sf, vf, res_pred_taken,
    input pred_taken, pred_ack, actual_taken, mispredict, illegal_br, br_count, mispred_count
  );
  modport slave (
    input pred_valid, pred_pc, res_valid, res_branch, res_pc, funct3, zf, cf, sf, vf, res_pred_taken,
    output pred_taken, pred_ack, actual_taken, mispredict, illegal_br, br_count, mispred_count
  );
endinterface

// File: rtl/branch_resolve_predict.sv
// branch_resolve_predict: 2-bit BHT predictor + B-type resolver with mispredict pulse and saturating stats; ports clk, rst (async high), bus (slave)
module branch_resolve_predict #(
  parameter int XLEN = 32,
  parameter int IDX_W = 6,
  parameter int CNT_W = 16,
  parameter logic [1:0] INIT_STATE = 2'b01
) (
  input logic clk,
  input logic rst,
  branch_resolve_predict_if.slave bus
);
  logic [1:0] bht [2**IDX_W];
  logic [IDX_W-1:0] pidx;
  logic [IDX_W-1:0] ridx;
  logic go;
  logic legal;
  logic upd;
  logic cond;
  logic unused_pc;
  assign pidx = bus.pred_pc[IDX_W+1:2];
  assign ridx = bus.res_pc[IDX_W+1:2];
  assign unused_pc = ^{bus.pred_pc[1:0], bus.pred_pc[XLEN-1:IDX_W+2], bus.res_pc[1:0], bus.res_pc[XLEN-1:IDX_W+2]};
  always_comb begin
    go = bus.res_valid & bus.res_branch;
    legal = bus.funct3[2:1] != 2'b01;
    upd = go & legal;
    cond = go & (bus.funct3[2:1] == 2'b00 ? bus.zf ^ bus.funct3[0] :
                 bus.funct3[2:1] == 2'b10 ? bus.sf ^ bus.vf ^ bus.funct3[0] :
                 bus.funct3[2:1] == 2'b11 ? ~(bus.cf ^ bus.funct3[0]) : 1'b0);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      bus.pred_taken <= 1'b0;
      bus.pred_ack <= 1'b0;
      bus.actual_taken <= 1'b0;
      bus.mispredict <= 1'b0;
      bus.illegal_br <= 1'b0;
      bus.br_count <= '0;
      bus.mispred_count <= '0;
      for (int i = 0; i < 2**IDX_W; i++) bht[i] <= INIT_STATE;
    end else begin
      bus.pred_ack <= bus.pred_valid;
      if (bus.pred_valid) bus.pred_taken <= bht[pidx][1];
      bus.actual_taken <= upd & cond;
      bus.mispredict <= upd & (cond ^ bus.res_pred_taken);
      bus.illegal_br <= go & ~legal;
      if (upd) bht[ridx] <= cond ? (bht[ridx] == 2'd3 ? 2'd3 : bht[ridx] + 2'd1)
                                 : (bht[ridx] == 2'd0 ? 2'd0 : bht[ridx] - 2'd1);
      if (upd && bus.br_count != {CNT_W{1'b1}}) bus.br_count <= bus.br_count + CNT_W'(1);
      if (upd && (cond ^ bus.res_pred_taken) && bus.mispred_count != {CNT_W{1'b1}})
        bus.mispred_count <= bus.mispred_count + CNT_W'(1);
    end
endmodule

// File: tb/tb_branch_resolve_predict.sv
// tb_branch_resolve_predict: randomized + directed self-check of branch_resolve_predict against a table-driven reference model
module tb_branch_resolve_predict;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_checks = 0;
  int n_fail = 0;
  int m_bht [64];
  int m_br;
  int m_mp;
  bit m_pt;
  bit m_pa;
  bit m_at;
  bit m_mis;
  bit m_ill;
  branch_resolve_predict_if #(.XLEN(32), .CNT_W(16)) b();
  branch_resolve_predict_if #(.XLEN(32), .CNT_W(4)) s();
  branch_resolve_predict #(.XLEN(32), .IDX_W(6), .CNT_W(16), .INIT_STATE(2'b01)) u_dut (.clk(clk), .rst(rst), .bus(b.slave));
  branch_resolve_predict #(.XLEN(32), .IDX_W(6), .CNT_W(4), .INIT_STATE(2'b01)) u_sat (.clk(clk), .rst(rst), .bus(s.slave));
  always #5 clk = ~clk;

  function automatic bit ref_cond(input logic [2:0] f, input bit zf, input bit cf, input bit sf, input bit vf);
    case (f)
      3'd0: return zf;
      3'd1: return !zf;
      3'd4: return sf != vf;
      3'd5: return sf == vf;
      3'd6: return !cf;
      3'd7: return cf;
      default: return 1'b0;
    endcase
  endfunction

  task automatic reset_model();
    for (int i = 0; i < 64; i++) m_bht[i] = 1;
    m_br = 0; m_mp = 0;
    m_pt = 0; m_pa = 0; m_at = 0; m_mis = 0; m_ill = 0;
  endtask

  task automatic idle();
    b.pred_valid = 0; b.pred_pc = 0; b.res_valid = 0; b.res_branch = 0; b.res_pc = 0;
    b.funct3 = 0; b.zf = 0; b.cf = 0; b.sf = 0; b.vf = 0; b.res_pred_taken = 0;
    s.pred_valid = 0; s.pred_pc = 0; s.res_valid = 0; s.res_branch = 0; s.res_pc = 0;
    s.funct3 = 0; s.zf = 0; s.cf = 0; s.sf = 0; s.vf = 0; s.res_pred_taken = 0;
  endtask

  task automatic set_res(input bit v, input bit br, input logic [31:0] pc, input logic [2:0] f,
                         input logic [3:0] flg, input bit pt);
    b.res_valid = v; b.res_branch = br; b.res_pc = pc; b.funct3 = f;
    {b.zf, b.cf, b.sf, b.vf} = flg; b.res_pred_taken = pt;
  endtask

  task automatic set_pred(input bit v, input logic [31:0] pc);
    b.pred_valid = v; b.pred_pc = pc;
  endtask

  // advance the reference model with the current inputs, then step past the edge
  task automatic tick();
    int pi;
    int ri;
    bit c;
    pi = int'(b.pred_pc[7:2]);
    ri = int'(b.res_pc[7:2]);
    m_pa = b.pred_valid;
    if (b.pred_valid) m_pt = m_bht[pi] >= 2;
    m_at = 0; m_mis = 0; m_ill = 0;
    if (b.res_valid && b.res_branch) begin
      if (b.funct3 == 3'd2 || b.funct3 == 3'd3) m_ill = 1;
      else begin
        c = ref_cond(b.funct3, b.zf, b.cf, b.sf, b.vf);
        m_at = c;
        m_mis = c != b.res_pred_taken;
        m_bht[ri] = c ? (m_bht[ri] < 3 ? m_bht[ri] + 1 : 3) : (m_bht[ri] > 0 ? m_bht[ri] - 1 : 0);
        if (m_br < 65535) m_br++;
        if (m_mis && m_mp < 65535) m_mp++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    reset_model();
    #12;
    n_checks++;
    if ({b.pred_taken, b.pred_ack, b.actual_taken, b.mispredict, b.illegal_br} !== 5'b0) begin
      n_fail++; $display("FAIL reset_outs got %b want 00000", {b.pred_taken, b.pred_ack, b.actual_taken, b.mispredict, b.illegal_br});
    end
    n_checks++;
    if (b.br_count !== 16'd0 || b.mispred_count !== 16'd0) begin
      n_fail++; $display("FAIL reset_counts got %0d/%0d want 0/0", b.br_count, b.mispred_count);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    set_pred(1, 32'h40);
    tick();
    n_checks++;
    if (b.pred_ack !== 1'b1 || b.pred_taken !== m_pt) begin
      n_fail++; $display("FAIL first_predict got ack=%b taken=%b want ack=1 taken=%b", b.pred_ack, b.pred_taken, m_pt);
    end
    set_pred(0, 0);
    tick();
    n_checks++;
    if (b.pred_ack !== 1'b0) begin
      n_fail++; $display("FAIL ack_drop got %b want 0", b.pred_ack);
    end
  endtask

  task automatic test_beq_mispredict();
    set_res(1, 1, 32'h40, 3'd0, 4'b1000, 0);
    tick();
    n_checks++;
    if (b.actual_taken !== 1'b1 || b.mispredict !== 1'b1) begin
      n_fail++; $display("FAIL beq_outcome got taken=%b mis=%b want 1 1", b.actual_taken, b.mispredict);
    end
    n_checks++;
    if (b.br_count !== 16'(m_br) || b.mispred_count !== 16'(m_mp) || m_br != 1) begin
      n_fail++; $display("FAIL beq_counts got %0d/%0d want %0d/%0d", b.br_count, b.mispred_count, m_br, m_mp);
    end
    idle();
    set_pred(1, 32'h40);
    tick();
    n_checks++;
    if (b.pred_taken !== 1'b1 || b.mispredict !== 1'b0) begin
      n_fail++; $display("FAIL beq_trained got pred=%b mis=%b want 1 0", b.pred_taken, b.mispredict);
    end
  endtask

  task automatic test_decode();
    logic [2:0] fl [6] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
    logic [3:0] fs [2] = '{4'b0110, 4'b1000};
    int br0;
    idle();
    for (int i = 0; i < 6; i++)
      for (int j = 0; j < 2; j++) begin
        set_res(1, 1, 32'h100 + 32'(4 * i), fl[i], fs[j], 1'($urandom));
        tick();
        n_checks++;
        if (b.actual_taken !== m_at || b.mispredict !== m_mis || b.illegal_br !== 1'b0) begin
          n_fail++; $display("FAIL decode f3=%0d flags=%b got t=%b m=%b i=%b want %b %b 0",
                             fl[i], fs[j], b.actual_taken, b.mispredict, b.illegal_br, m_at, m_mis);
        end
      end
    br0 = m_br;
    set_res(1, 0, 32'h40, 3'd0, 4'b1000, 0);
    tick();
    n_checks++;
    if (b.actual_taken !== 1'b0 || b.mispredict !== 1'b0 || b.br_count !== 16'(br0)) begin
      n_fail++; $display("FAIL non_branch got t=%b m=%b cnt=%0d want 0 0 %0d", b.actual_taken, b.mispredict, b.br_count, br0);
    end
  endtask

  task automatic test_illegal();
    int br0;
    int mp0;
    br0 = m_br; mp0 = m_mp;
    set_res(1, 1, 32'h44, 3'd2, 4'b1111, 0);
    tick();
    n_checks++;
    if (b.illegal_br !== 1'b1 || b.actual_taken !== 1'b0 || b.mispredict !== 1'b0) begin
      n_fail++; $display("FAIL illegal_pulse got i=%b t=%b m=%b want 1 0 0", b.illegal_br, b.actual_taken, b.mispredict);
    end
    idle();
    tick();
    n_checks++;
    if (b.illegal_br !== 1'b0 || b.br_count !== 16'(br0) || b.mispred_count !== 16'(mp0)) begin
      n_fail++; $display("FAIL illegal_after got i=%b cnt=%0d/%0d want 0 %0d/%0d", b.illegal_br, b.br_count, b.mispred_count, br0, mp0);
    end
    set_pred(1, 32'h44);
    tick();
    n_checks++;
    if (b.pred_taken !== 1'b0) begin
      n_fail++; $display("FAIL illegal_bht got pred=%b want 0", b.pred_taken);
    end
  endtask

  task automatic test_bht_saturate();
    idle();
    for (int i = 0; i < 4; i++) begin
      set_res(1, 1, 32'h80, 3'd0, 4'b1000, 1);
      tick();
    end
    set_res(1, 1, 32'h80, 3'd0, 4'b0000, 1);
    tick();
    idle();
    set_pred(1, 32'h80);
    tick();
    n_checks++;
    if (b.pred_taken !== 1'b1 || m_bht[32] != 2) begin
      n_fail++; $display("FAIL bht_sat got pred=%b want 1", b.pred_taken);
    end
    // counter is 2: a simultaneous not-taken update drops it to 1, read must still see 2
    set_res(1, 1, 32'h80, 3'd0, 4'b0000, 0);
    set_pred(1, 32'h80);
    tick();
    n_checks++;
    if (b.pred_taken !== 1'b1) begin
      n_fail++; $display("FAIL collision_old got pred=%b want 1", b.pred_taken);
    end
    idle();
    set_pred(1, 32'h80);
    tick();
    n_checks++;
    if (b.pred_taken !== 1'b0) begin
      n_fail++; $display("FAIL collision_commit got pred=%b want 0", b.pred_taken);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      set_pred($urandom_range(0, 1) == 1, ($urandom & 32'hFFFF_FF03) | 32'($urandom_range(0, 15) << 2));
      set_res($urandom_range(0, 3) != 0, $urandom_range(0, 5) != 0,
              ($urandom & 32'hFFFF_FF03) | 32'($urandom_range(0, 15) << 2),
              3'($urandom), 4'($urandom), 1'($urandom));
      tick();
      n_checks++;
      if ({b.pred_taken, b.pred_ack, b.actual_taken, b.mispredict, b.illegal_br} !== {m_pt, m_pa, m_at, m_mis, m_ill}
          || b.br_count !== 16'(m_br) || b.mispred_count !== 16'(m_mp)) begin
        n_fail++; $display("FAIL random[%0d] got %b %0d/%0d want %b %0d/%0d", n,
                           {b.pred_taken, b.pred_ack, b.actual_taken, b.mispredict, b.illegal_br}, b.br_count, b.mispred_count,
                           {m_pt, m_pa, m_at, m_mis, m_ill}, m_br, m_mp);
      end
    end
    idle();
  endtask

  task automatic test_stat_saturate();
    int e;
    s.res_valid = 1; s.res_branch = 1; s.res_pc = 32'h40; s.funct3 = 3'd0; s.zf = 1; s.res_pred_taken = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      e = i > 15 ? 15 : i;
      n_checks++;
      if (s.br_count !== 4'(e) || s.mispred_count !== 4'(e)) begin
        n_fail++; $display("FAIL stat_sat[%0d] got %0d/%0d want %0d/%0d", i, s.br_count, s.mispred_count, e, e);
      end
    end
    idle();
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) begin
      set_res(1, 1, 32'h80, 3'd0, 4'b1000, 0);
      set_pred(1, 32'h80);
      tick();
    end
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({b.pred_taken, b.pred_ack, b.actual_taken, b.mispredict, b.illegal_br} !== 5'b0
        || b.br_count !== 16'd0 || b.mispred_count !== 16'd0 || s.br_count !== 4'd0) begin
      n_fail++; $display("FAIL async_reset got %b %0d/%0d want 00000 0/0",
                         {b.pred_taken, b.pred_ack, b.actual_taken, b.mispredict, b.illegal_br}, b.br_count, b.mispred_count);
    end
    reset_model();
    idle();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    set_pred(1, 32'h80);
    tick();
    n_checks++;
    if (b.pred_taken !== 1'b0) begin
      n_fail++; $display("FAIL reset_bht_cleared got pred=%b want 0", b.pred_taken);
    end
    set_pred(0, 0);
    set_res(1, 1, 32'h80, 3'd7, 4'b0100, 1);
    tick();
    idle();
    set_pred(1, 32'h80);
    tick();
    n_checks++;
    if (b.pred_taken !== m_pt || m_pt != 1'b1) begin
      n_fail++; $display("FAIL reset_bht_init got pred=%b want %b", b.pred_taken, m_pt);
    end
  endtask

  initial begin
    test_reset();
    test_beq_mispredict();
    test_decode();
    test_illegal();
    test_bht_saturate();
    test_random();
    test_stat_saturate();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/branch_resolve_predict.md
Name: branch_resolve_predict

Overview:
Parametrised next-generation branch control for the RV32I core. It resolves B-type conditions from ALU flags, as the existing combinational branch control does, and adds a 2-bit saturating-counter branch history table (BHT) for prediction. It also registers the resolution result and flags mispredictions, and keeps saturating branch/mispredict statistics counters. It sits between the fetch stage (predict port) and the execute stage (resolve port).

Parameters:
XLEN, 32, width of PC inputs
IDX_W, 6, BHT index width; table holds 2**IDX_W 2-bit counters; index = pc[IDX_W+1:2]
CNT_W, 16, width of statistics counters
INIT_STATE, 2'b01, reset value of every BHT counter (weakly not-taken)

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
pred_valid  in  1  fetch requests a prediction this cycle
pred_pc  in  XLEN  PC of fetched instruction
pred_taken  out  1  registered prediction, valid the cycle after pred_valid
pred_ack  out  1  registered; high the cycle after pred_valid
res_valid  in  1  execute presents an instruction for resolution
res_branch  in  1  instruction is B-type
res_pc  in  XLEN  PC of resolving instruction
funct3  in  3  branch funct3
zf, cf, sf, vf  in  1 each  ALU flags from rs1-rs2 (cf=1 means no borrow, i.e. rs1>=rs2 unsigned)
res_pred_taken  in  1  prediction that travelled with the instruction
actual_taken  out  1  registered resolved outcome
mispredict  out  1  registered; one-cycle pulse
illegal_br  out  1  registered; one-cycle pulse for reserved funct3
br_count  out  CNT_W  resolved legal branches, saturating
mispred_count  out  CNT_W  mispredictions, saturating

Behaviour:
- Reset (async, rst=1): pred_taken, pred_ack, actual_taken, mispredict and illegal_br are 0. br_count and mispred_count are 0. All BHT entries equal INIT_STATE. Reset asserted mid-operation discards any in-flight registered result immediately.
- Condition decode, combinational and internal; cond is forced to 0 unless res_branch=1:
  - 000 BEQ: zf
  - 001 BNE: ~zf
  - 100 BLT: sf!=vf
  - 101 BGE: sf==vf
  - 110 BLTU: ~cf
  - 111 BGEU: cf
  - 010, 011: reserved, cond=0
- Resolve stage, 1-cycle latency. When res_valid & res_branch are high at edge N, outputs update at edge N:
  - Legal funct3: actual_taken=cond; mispredict=(cond!=res_pred_taken); illegal_br=0.
  - Reserved funct3: actual_taken=0, mispredict=0, illegal_br=1. No BHT or counter update.
- Resolve stage, idle case: when res_valid=0 or res_branch=0, actual_taken, mispredict and illegal_br all return to 0 next edge (pulse semantics).
- BHT update, on a legal resolve only, at index res_pc[IDX_W+1:2]:
  - Taken: counter+1, saturating at 3.
  - Not taken: counter-1, saturating at 0.
- Predict stage: when pred_valid is high at edge N, pred_taken=BHT[pred_pc[IDX_W+1:2]][1] and pred_ack=1 after edge N. Otherwise pred_ack=0 and pred_taken holds its value.
- Same-index collision: a read and an update to the same entry in the same cycle return the pre-update value (read-before-write). The update still commits.
- Statistics:
  - br_count increments on every legal resolve.
  - mispred_count increments on each legal mispredict.
  - Both stick at 2**CNT_W-1 and never wrap.
- PC bits [1:0] and bits above IDX_W+1 are ignored; aliasing is permitted.
- No stalls or backpressure: both ports accept every cycle.

Test Plan:
- Reset then predict pc=0x40 -> pred_ack=1 and pred_taken=0 next cycle; all counters 0.
- Resolve BEQ, zf=1, res_pred_taken=0, pc=0x40 -> actual_taken=1, mispredict=1, br_count=1, mispred_count=1. A later predict of 0x40 gives pred_taken=1 (counter 01->10).
- All six legal funct3 with flag sets (zf,cf,sf,vf)=(0,1,1,0) and (1,0,0,0) -> outcomes match the decode table. res_branch=0 with BEQ, zf=1 -> actual_taken=0, no count.
- funct3=010 with res_branch=1 -> illegal_br pulse for one cycle, actual_taken=0, BHT and counters unchanged.
- Four taken resolves at pc=0x80 -> counter saturates at 3; one not-taken -> 2; pred_taken stays 1. Simultaneous predict and update on 0x80 returns the old value.
- CNT_W=4 build, 20 mispredicting branches -> both counters hold 15. Asserting rst mid-stream clears all outputs asynchronously and restores the BHT to INIT_STATE.
